elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Car-motion controller for the 8-floor elevator; consumes the latched per-floor request levels from the pulse-to-level request latch and sequences car movement, door open/close and request clearing. Implements SCAN (collective) scheduling: keep direction while requests lie ahead, otherwise reverse or idle. Drives the latch's per-floor clear bus and the floor/direction/door status used by display and motor logic.

Parameters:
NUM_FLOORS, 8, number of floors; request/clear bus width
MOVE_CYCLES, 50000000, clk cycles to travel one floor (≥2)
DOOR_CYCLES, 150000000, clk cycles door stays open (≥2)
SETTLE_CYCLES, 2, cycles in CLOSE before next decision (≥2; covers latch clear latency)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_FLOORS  latched request levels, bit k = floor k pending
hold_door  in  1  door-hold button, level
req_clear  out  NUM_FLOORS  per-floor clear to request latch, registered
cur_floor  out  FLOOR_W  current car floor, registered
dir_up  out  1  1 = up/last up, 0 = down
moving  out  1  high in MOVE
door_open  out  1  high in DOOR
ctrl_state  out  2  IDLE=0, MOVE=1, DOOR=2, CLOSE=3

Behaviour:
- Reset (reset high at clk edge): state IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, req_clear=0, timers=0. Reset mid-move or mid-door aborts immediately; car model returns to floor 0.
- All outputs registered; decisions use req sampled at the same edge.
- Derived: at_floor=req[cur_floor]; any_above=|req[top:cur_floor+1]; any_below=|req[cur_floor-1:0]; any_above=0 at top floor, any_below=0 at floor 0.
- IDLE, priority order: at_floor -> DOOR; else dir_up & any_above -> MOVE; else ~dir_up & any_below -> MOVE; else any_above -> dir_up=1, MOVE; else any_below -> dir_up=0, MOVE; else stay. Direction change and entry to MOVE occur on the same edge.
- MOVE: moving=1; timer counts 0..MOVE_CYCLES-1; at terminal count cur_floor ±1 per dir_up and timer clears. On the arrival edge, evaluate against the new floor: req[new] -> DOOR; else requests ahead in dir_up -> stay MOVE; else -> IDLE, which re-decides next cycle and reverses if needed. Requests withdrawn mid-travel do not stop the car between floors. Never increments past NUM_FLOORS-1 or decrements below 0.
- DOOR: door_open=1; req_clear = one-hot(cur_floor) every cycle in DOOR, so presses at this floor while the door is open are absorbed. Timer counts DOOR_CYCLES cycles; hold_door high reloads timer to 0. Timer expiry with hold_door low -> CLOSE.
- CLOSE: door_open=0, req_clear=0; lasts SETTLE_CYCLES cycles; then IDLE. Stale at_floor from latch latency is never acted on.
- Simultaneous arrival and new press at the arrival floor (same edge): stop at that floor.
- Travel latency: floor f to k with no intermediate stops = 1 decision cycle + |k-f|*MOVE_CYCLES; door opens on the arrival edge.
- Timer width: clog2(max(MOVE_CYCLES, DOOR_CYCLES, SETTLE_CYCLES)+1); all floor arithmetic is unsigned FLOOR_W with no wrap.

Decomposition:
- Package elevator_pkg: FLOOR_W = clog2(NUM_FLOORS), ctrl_state enum (IDLE/MOVE/DOOR/CLOSE), default timing constants.
- One combinational sub-module elevator_req_lookahead (req, cur_floor -> at_floor, any_above, any_below); FSM, timer and floor counter stay in elevator_scheduler.

Test Plan (MOVE_CYCLES=4, DOOR_CYCLES=3, SETTLE_CYCLES=2):
- Reset then req=8'h00 for 20 cycles -> ctrl_state=IDLE, cur_floor=0, dir_up=1, all outputs 0 throughout.
- At floor 0, req=8'b0000_1000 -> MOVE next edge; cur_floor steps 1,2,3 every 4 cycles; DOOR on arrival at 3; req_clear=8'h08 for 3 cycles; CLOSE 2 cycles; IDLE.
- Car moving up past floor 2 with req[5] set; assert req[1] and req[4] -> stops at 4 then 5, then reverses (dir_up=0) and serves 1.
- req[cur_floor] rises on the same edge as arrival at floor 2 while heading to 6 -> DOOR at floor 2, then continues up to 6.
- In DOOR, hold hold_door high for 10 cycles -> door_open stays 1 for 10 cycles + 3 after release; press req[cur_floor] during DOOR -> no second door cycle.
- Assert reset mid-MOVE between floors 3 and 4 -> next edge cur_floor=0, IDLE, moving=0, req_clear=0; top-floor request at floor 7 -> no increment beyond 7.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and timing defaults for the elevator car controller.
// Floor index width, controller state encoding and sizing helpers.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS    = 8;
  localparam int DEF_MOVE_CYCLES   = 50_000_000;
  localparam int DEF_DOOR_CYCLES   = 150_000_000;
  localparam int DEF_SETTLE_CYCLES = 2;

  localparam int FLOOR_W = $clog2(DEF_NUM_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DOOR  = 2'd2,
    ST_CLOSE = 2'd3
  } ctrl_state_e;

  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/elevator_req_lookahead.sv
// Combinational request view relative to one floor: pending here,
// pending anywhere above, pending anywhere below.
module elevator_req_lookahead
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FW         = floor_w(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FW-1:0]         floor,
  output logic                  at_floor,
  output logic                  any_above,
  output logic                  any_below
);

  always_comb begin
    at_floor  = 1'b0;
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(floor)) begin
        at_floor = at_floor | req[i];
      end else if (i > int'(floor)) begin
        any_above = any_above | req[i];
      end else begin
        any_below = any_below | req[i];
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: sequences travel, door dwell and request clearing
// from latched per-floor request levels; all outputs registered.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int MOVE_CYCLES   = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int FW           = floor_w(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  hold_door,
  output logic [NUM_FLOORS-1:0] req_clear,
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [1:0]            ctrl_state
);

  localparam int TW = timer_w(MOVE_CYCLES, DOOR_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] MOVE_LAST   = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);

  ctrl_state_e           state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic                  moving_q, moving_d;
  logic                  door_open_q, door_open_d;
  logic [NUM_FLOORS-1:0] req_clear_q, req_clear_d;

  logic [FW-1:0] next_floor;
  logic [FW-1:0] eval_floor;
  logic          arrive;
  logic          at_floor;
  logic          any_above;
  logic          any_below;
  logic          ahead;

  always_comb begin
    next_floor = floor_q;
    if (dir_up_q && (floor_q != TOP_FLOOR)) begin
      next_floor = floor_q + FW'(1);
    end else if (!dir_up_q && (floor_q != '0)) begin
      next_floor = floor_q - FW'(1);
    end
  end

  // On the arrival edge every decision is taken against the floor being entered.
  assign arrive     = (state_q == ST_MOVE) && (timer_q == MOVE_LAST);
  assign eval_floor = arrive ? next_floor : floor_q;

  elevator_req_lookahead #(
    .NUM_FLOORS (NUM_FLOORS),
    .FW         (FW)
  ) u_lookahead (
    .req       (req),
    .floor     (eval_floor),
    .at_floor  (at_floor),
    .any_above (any_above),
    .any_below (any_below)
  );

  assign ahead = dir_up_q ? any_above : any_below;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (at_floor) begin
          state_d = ST_DOOR;
        end else if (ahead) begin
          state_d = ST_MOVE;
        end else if (any_above) begin
          dir_up_d = 1'b1;
          state_d  = ST_MOVE;
        end else if (any_below) begin
          dir_up_d = 1'b0;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (arrive) begin
          timer_d = '0;
          floor_d = next_floor;
          if (at_floor) begin
            state_d = ST_DOOR;
          end else if (!ahead) begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DOOR: begin
        if (hold_door) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = ST_CLOSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CLOSE: begin
        // Dwell lets the latch drop this floor's bit before the next decision.
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    req_clear_d = '0;
    if (state_d == ST_DOOR) begin
      req_clear_d[floor_d] = 1'b1;
    end
    moving_d    = (state_d == ST_MOVE);
    door_open_d = (state_d == ST_DOOR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      req_clear_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      req_clear_q <= req_clear_d;
    end
  end

  assign req_clear  = req_clear_q;
  assign cur_floor  = floor_q;
  assign dir_up     = dir_up_q;
  assign moving     = moving_q;
  assign door_open  = door_open_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler with a behavioural request latch; door-open
// events are scoreboarded against expected floor, cycle and direction.
module tb_elevator_scheduler;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       hold_door = 1'b0;
  logic [7:0] req       = 8'h00;
  logic [7:0] press     = 8'h00;
  logic [7:0] req_clear;
  logic [2:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [1:0] ctrl_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int   floor;
    int   cyc;
    logic up;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic door_prev = 1'b0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .NUM_FLOORS    (8),
    .MOVE_CYCLES   (4),
    .DOOR_CYCLES   (3),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .hold_door  (hold_door),
    .req_clear  (req_clear),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .ctrl_state (ctrl_state)
  );

  // Request latch: a press sets the level, the clear bus wins on the same edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) req <= 8'h00;
    else       req <= (req | press) & ~req_clear;
  end

  always @(negedge clk) begin
    if (door_open && !door_prev)
      obs_q.push_back('{floor: int'(cur_floor), cyc: cyc, up: dir_up});
    door_prev <= door_open;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    press = 8'h00;
    hold_door = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({ctrl_state, cur_floor, dir_up, moving, door_open, req_clear} !==
          {2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got st=%0d fl=%0d up=%0d mv=%0d door=%0d clr=%h, want 0 0 1 0 0 00",
                 cyc, ctrl_state, cur_floor, dir_up, moving, door_open, req_clear);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_trip();
    int c;
    int n_clr = 0;
    int n_close = 0;
    ev_t e;
    ev_t o;
    do_reset();
    c = cyc;
    press = 8'h08;
    @(negedge clk);
    press = 8'h00;
    exp_q.push_back('{floor: 3, cyc: c + 14, up: 1'b1});
    wait_cyc(c + 2);
    n_checks++;
    if (ctrl_state !== 2'd1 || moving !== 1'b1 || cur_floor !== 3'd0) begin
      n_fail++;
      $display("FAIL trip_start got st=%0d mv=%0d fl=%0d, want 1 1 0", ctrl_state, moving, cur_floor);
    end
    wait_cyc(c + 6);
    n_checks++;
    if (cur_floor !== 3'd1) begin
      n_fail++;
      $display("FAIL trip_floor1 got %0d, want 1", cur_floor);
    end
    wait_cyc(c + 10);
    n_checks++;
    if (cur_floor !== 3'd2) begin
      n_fail++;
      $display("FAIL trip_floor2 got %0d, want 2", cur_floor);
    end
    wait_cyc(c + 14);
    for (int i = 0; i < 6; i++) begin
      if (req_clear == 8'h08) n_clr++;
      if (ctrl_state == 2'd3) n_close++;
      @(negedge clk);
    end
    n_checks++;
    if (n_clr !== 3 || n_close !== 2) begin
      n_fail++;
      $display("FAIL trip_dwell got clear_cycles=%0d close_cycles=%0d, want 3 2", n_clr, n_close);
    end
    n_checks++;
    if (ctrl_state !== 2'd0 || cur_floor !== 3'd3 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL trip_end got st=%0d fl=%0d door=%0d, want 0 3 0", ctrl_state, cur_floor, door_open);
    end
    wait_obs(1, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL trip_door no door event, want floor %0d at cyc %0d", e.floor, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.floor !== e.floor || o.cyc !== e.cyc || o.up !== e.up) begin
          n_fail++;
          $display("FAIL trip_door got fl=%0d cyc=%0d up=%0d, want fl=%0d cyc=%0d up=%0d",
                   o.floor, o.cyc, o.up, e.floor, e.cyc, e.up);
        end
      end
    end
  endtask

  task automatic test_scan();
    int c;
    ev_t e;
    ev_t o;
    do_reset();
    c = cyc;
    press = 8'h20;
    @(negedge clk);
    press = 8'h00;
    exp_q.push_back('{floor: 4, cyc: c + 18, up: 1'b1});
    exp_q.push_back('{floor: 5, cyc: c + 28, up: 1'b1});
    exp_q.push_back('{floor: 1, cyc: c + 50, up: 1'b0});
    wait_cyc(c + 14);
    n_checks++;
    if (cur_floor !== 3'd3 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_pos got fl=%0d mv=%0d, want 3 1", cur_floor, moving);
    end
    press = 8'h12;
    @(negedge clk);
    press = 8'h00;
    wait_obs(3, 120);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL scan_door no door event, want floor %0d at cyc %0d", e.floor, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.floor !== e.floor || o.cyc !== e.cyc || o.up !== e.up) begin
          n_fail++;
          $display("FAIL scan_door got fl=%0d cyc=%0d up=%0d, want fl=%0d cyc=%0d up=%0d",
                   o.floor, o.cyc, o.up, e.floor, e.cyc, e.up);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    int c;
    ev_t e;
    ev_t o;
    do_reset();
    c = cyc;
    press = 8'h40;
    @(negedge clk);
    press = 8'h00;
    wait_cyc(c + 8);
    n_checks++;
    if (cur_floor !== 3'd1 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL same_edge_pos got fl=%0d mv=%0d, want 1 1", cur_floor, moving);
    end
    // Latched on the next edge, so the controller first samples it on the arrival edge at 2.
    press = 8'h04;
    @(negedge clk);
    press = 8'h00;
    exp_q.push_back('{floor: 2, cyc: c + 10, up: 1'b1});
    exp_q.push_back('{floor: 6, cyc: c + 32, up: 1'b1});
    wait_obs(2, 80);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL same_edge_door no door event, want floor %0d at cyc %0d", e.floor, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.floor !== e.floor || o.cyc !== e.cyc || o.up !== e.up) begin
          n_fail++;
          $display("FAIL same_edge_door got fl=%0d cyc=%0d up=%0d, want fl=%0d cyc=%0d up=%0d",
                   o.floor, o.cyc, o.up, e.floor, e.cyc, e.up);
        end
      end
    end
  endtask

  task automatic test_hold_door();
    int c;
    int n_open = 0;
    ev_t e;
    ev_t o;
    do_reset();
    c = cyc;
    press = 8'h02;
    @(negedge clk);
    press = 8'h00;
    exp_q.push_back('{floor: 1, cyc: c + 6, up: 1'b1});
    wait_cyc(c + 6);
    hold_door = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (door_open) n_open++;
      @(negedge clk);
    end
    hold_door = 1'b0;
    for (int i = 0; i < 8; i++) begin
      press = (cyc == c + 18) ? 8'h02 : 8'h00;
      if (door_open) n_open++;
      @(negedge clk);
    end
    press = 8'h00;
    n_checks++;
    if (n_open !== 13) begin
      n_fail++;
      $display("FAIL hold_door_len got %0d open cycles, want 13", n_open);
    end
    wait_cyc(c + 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL hold_door_evt no door event, want floor %0d at cyc %0d", e.floor, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.floor !== e.floor || o.cyc !== e.cyc || o.up !== e.up) begin
          n_fail++;
          $display("FAIL hold_door_evt got fl=%0d cyc=%0d up=%0d, want fl=%0d cyc=%0d up=%0d",
                   o.floor, o.cyc, o.up, e.floor, e.cyc, e.up);
        end
      end
    end
    n_checks++;
    if (obs_q.size() !== 0 || ctrl_state !== 2'd0 || cur_floor !== 3'd1) begin
      n_fail++;
      $display("FAIL hold_door_absorb got extra_doors=%0d st=%0d fl=%0d, want 0 0 1",
               obs_q.size(), ctrl_state, cur_floor);
    end
  endtask

  task automatic test_reset_mid_move();
    int c;
    ev_t e;
    ev_t o;
    do_reset();
    c = cyc;
    press = 8'h80;
    @(negedge clk);
    press = 8'h00;
    wait_cyc(c + 15);
    n_checks++;
    if (cur_floor !== 3'd3 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_move_pos got fl=%0d mv=%0d, want 3 1", cur_floor, moving);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ctrl_state, cur_floor, dir_up, moving, door_open, req_clear} !==
        {2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_move_reset got st=%0d fl=%0d up=%0d mv=%0d door=%0d clr=%h, want 0 0 1 0 0 00",
               ctrl_state, cur_floor, dir_up, moving, door_open, req_clear);
    end
    reset = 1'b0;
    obs_q.delete();
    c = cyc;
    press = 8'h80;
    @(negedge clk);
    press = 8'h00;
    exp_q.push_back('{floor: 7, cyc: c + 30, up: 1'b1});
    wait_obs(1, 60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL top_floor_door no door event, want floor %0d at cyc %0d", e.floor, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.floor !== e.floor || o.cyc !== e.cyc || o.up !== e.up) begin
          n_fail++;
          $display("FAIL top_floor_door got fl=%0d cyc=%0d up=%0d, want fl=%0d cyc=%0d up=%0d",
                   o.floor, o.cyc, o.up, e.floor, e.cyc, e.up);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (cur_floor !== 3'd7 || moving !== 1'b0) begin
        n_fail++;
        $display("FAIL top_floor_hold cyc=%0d got fl=%0d mv=%0d, want 7 0", cyc, cur_floor, moving);
      end
    end
    n_checks++;
    if (ctrl_state !== 2'd0) begin
      n_fail++;
      $display("FAIL top_floor_idle got st=%0d, want 0", ctrl_state);
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_scan();
    test_same_edge();
    test_hold_door();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
